ifetch_buf: RTL

Instruction fetch stage between the PC register and the IF/ID pipeline register. It issues the current PC on the instruction bus and tracks in-flight reads. Returned instructions go into a small in-order prefetch queue, which decode drains through a valid/ready handshake. It throttles the PC register through `hold_o` and discards queued and in-flight fetches on a jump flush.

---
 rtl/ifetch_buf.sv | 108 ++++++++++
 1 files changed

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: issues PC reads, tracks outstanding responses, queues
// returned instructions in order for decode, and absorbs stale responses after a flush.
module ifetch_buf #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   output logic        hold_o,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ready_i
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [PW-1:0]    head_q, fill_q, tail_q;
   logic [CW-1:0]    count_q, drop_q;

   logic          pop, grant, credit, rsp_drop, rsp_fill;
   logic [CW-1:0] nfilled, unfilled;
   logic [CW:0]   occ;

   always_comb begin
      nfilled = '0;
      for (int i = 0; i < DEPTH; i++)
         nfilled = nfilled + {{(CW-1){1'b0}}, filled_q[i]};
   end

   // Allocated entries still waiting for their response.
   assign unfilled = count_q - nfilled;

   assign occ    = {1'b0, count_q} + {1'b0, drop_q} - {{CW{1'b0}}, pop};
   assign credit = occ < (CW+1)'(DEPTH);

   assign inst_valid_o = filled_q[head_q] & ~flush_i & ~rst;
   assign pop          = inst_valid_o & inst_ready_i;
   assign ibus_req_o   = credit & ~flush_i & ~rst;
   assign grant        = ibus_req_o & ibus_gnt_i;
   assign hold_o       = ~grant;
   assign ibus_addr_o  = pc_i;
   assign inst_o       = inst_valid_o ? data_q[head_q] : NOP;
   assign inst_addr_o  = inst_valid_o ? addr_q[head_q] : 32'h0;

   assign rsp_drop = ibus_rvalid_i & (drop_q != '0);
   assign rsp_fill = ibus_rvalid_i & (drop_q == '0);

   // Control state: pointers, occupancy, filled flags
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         head_q   <= '0;
         fill_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         filled_q <= '0;
      end else begin
         if (grant)
            tail_q <= tail_q + 1'b1;
         if (rsp_fill)
            fill_q <= fill_q + 1'b1;
         if (pop)
            head_q <= head_q + 1'b1;
         count_q <= count_q + {{(CW-1){1'b0}}, grant} - {{(CW-1){1'b0}}, pop};
         for (int i = 0; i < DEPTH; i++) begin
            if (rsp_fill && fill_q == PW'(i))
               filled_q[i] <= 1'b1;
            else if (pop && head_q == PW'(i))
               filled_q[i] <= 1'b0;
         end
      end
   end

   // On flush every outstanding read becomes owed-and-discarded, less any response consumed now.
   always_ff @(posedge clk) begin
      if (rst)
         drop_q <= '0;
      else if (flush_i)
         drop_q <= drop_q + unfilled - {{(CW-1){1'b0}}, ibus_rvalid_i};
      else if (rsp_drop)
         drop_q <= drop_q - 1'b1;
   end

   // Queue payload
   always_ff @(posedge clk) begin
      if (grant)
         addr_q[tail_q] <= pc_i;
      if (rsp_fill)
         data_q[fill_q] <= ibus_rdata_i;
   end

   a_rsp_owed: assert property (@(posedge clk) disable iff (rst)
      !(rsp_fill && unfilled == '0));

   a_occupancy: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, count_q} + {1'b0, drop_q}) <= (CW+1)'(DEPTH));

endmodule
